// File: rtl/mem_arbiter_if.sv
// Bundle between the MIPS pipeline fetch/data ports, the arbiter and the single-port Memory.
// slave = arbiter view; master = pipeline + memory view.
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [31:0]   i_rdata;
    logic          i_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          d_stall;
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_d;
    logic [31:0]   mem_q;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output i_ack, i_rdata, i_stall, d_ack, d_rdata, d_err, d_stall,
               mem_cen, mem_wen, mem_a, mem_d
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  i_ack, i_rdata, i_stall, d_ack, d_rdata, d_err, d_stall,
               mem_cen, mem_wen, mem_a, mem_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port, one-cycle-latency memory between fetch and data ports.
// Data has priority; a starvation counter forces a fetch after STARVE_MAX data issues.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_DERR} owner_t;

    owner_t        owner, owner_nx;
    logic [SW-1:0] starve, starve_nx;
    logic          i_elig, d_elig, sel_i, sel_d, d_mis;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            owner  <= OWN_NONE;
            starve <= '0;
        end else begin
            owner  <= owner_nx;
            starve <= starve_nx;
        end
    end

    always_comb begin
        owner_nx    = OWN_NONE;
        starve_nx   = starve;
        bus.mem_cen = 1'b0;
        bus.mem_wen = 1'b0;
        bus.mem_a   = '0;
        bus.mem_d   = '0;

        // A port whose response is returning this cycle still holds req high, so mask it.
        // Nothing issues while reset is asserted.
        i_elig = nrst && bus.i_req && (owner != OWN_I);
        d_elig = nrst && bus.d_req && (owner != OWN_D) && (owner != OWN_DERR);
        sel_d  = d_elig && !(i_elig && (starve == SW'(STARVE_MAX)));
        sel_i  = i_elig && !sel_d;
        d_mis  = (bus.d_addr[1:0] != 2'b00);

        if (sel_d) begin
            if (d_mis) begin
                owner_nx = OWN_DERR;
            end else begin
                owner_nx    = OWN_D;
                bus.mem_cen = 1'b1;
                bus.mem_wen = bus.d_we;
                bus.mem_a   = bus.d_addr;
                bus.mem_d   = bus.d_wdata;
            end
        end else if (sel_i) begin
            owner_nx    = OWN_I;
            bus.mem_cen = 1'b1;
            bus.mem_a   = bus.i_addr;
        end

        if (sel_i || !bus.i_req)
            starve_nx = '0;
        else if (sel_d && (starve != SW'(STARVE_MAX)))
            starve_nx = starve + 1'b1;

        bus.i_ack   = (owner == OWN_I);
        bus.i_rdata = bus.i_ack ? bus.mem_q : 32'h0;
        bus.d_ack   = (owner == OWN_D) || (owner == OWN_DERR);
        bus.d_err   = (owner == OWN_DERR);
        bus.d_rdata = ((owner == OWN_D) && !bus.d_we) ? bus.mem_q : 32'h0;
        bus.i_stall = bus.i_req & ~bus.i_ack;
        bus.d_stall = bus.d_req & ~bus.d_ack;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous Memory block between the instruction-fetch port (read-only) and the data port (load/store) of the MIPS pipeline.
- Sequences every access into the memory's one-cycle-latency CEN/WEN/A/D/Q interface and returns the response to the owning port.
- Drives per-port stall signals to the pipeline.
- Data port has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- STARVE_MAX, 4: maximum consecutive data-port issues allowed while i_req is pending before fetch is forced.
- AW, 32: address width of both ports and of mem_a.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  AW  fetch byte address
- i_ack  out  1  one-cycle response pulse; i_rdata valid this cycle
- i_rdata  out  32  fetched word
- i_stall  out  1  i_req & ~i_ack
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle response pulse
- d_rdata  out  32  load data, valid with d_ack when d_we=0
- d_err  out  1  pulses with d_ack when the access was misaligned
- d_stall  out  1  d_req & ~d_ack
- mem_cen  out  1  to Memory CEN
- mem_wen  out  1  to Memory WEN
- mem_a  out  AW  to Memory A
- mem_d  out  32  to Memory D
- mem_q  in  32  from Memory Q; valid the cycle after issue

Behaviour:
- The top level ties the memory's Hold and Flush inputs low. The arbiter owns CEN, WEN, A and D exclusively.
- Registered state:
  - owner: NONE, I, D or DERR. This is the port whose response is due this cycle.
  - starve: counter 0..STARVE_MAX.
- Issue (combinational, cycle t). A port is eligible when its req is 1 and owner != that port. A port whose response is returning is masked, because its req is still high.
  - D is selected if eligible, unless starve == STARVE_MAX and I is eligible. In that case I is selected.
  - Otherwise I is selected if eligible. If neither is eligible, nothing is issued.
- Selecting D with d_addr[1:0] != 0: mem_cen=0 and owner_next=DERR. No memory access occurs.
- Selecting a valid port:
  - mem_cen=1.
  - mem_a is the selected address.
  - For D: mem_wen=d_we and mem_d=d_wdata.
  - For I: mem_wen=0 and mem_d=0.
  - owner_next is the selected port.
- Idle drive: mem_cen=0, mem_wen=0, mem_a=0, mem_d=0. Bus values are never left X.
- Response (cycle t+1):
  - owner=I: i_ack=1 and i_rdata=mem_q.
  - owner=D: d_ack=1, d_rdata = d_we ? 0 : mem_q. A store is committed at the edge ending cycle t.
  - owner=DERR: d_ack=1, d_err=1, d_rdata=0.
  - Acks and rdata are combinational from owner and mem_q. Both are 0 when not acked.
- Throughput:
  - A single port completes at most one access per 2 cycles.
  - Alternating I/D requests keep the memory busy every cycle. Example: I issued at t and D issued at t+1 while I's response returns.
- Starvation counter:
  - Increments (saturating) when D is issued while i_req=1.
  - Clears when I is issued or when i_req=0.
- Reset (nrst=0, asynchronous): owner=NONE and starve=0. Therefore all acks, d_err and mem_cen are 0 and all data outputs are 0.
- Reset mid-operation: an in-flight response is dropped with no ack. Requesters re-present after reset.
- Simultaneous events:
  - Both requests arriving in the same cycle: D wins and I is issued the following cycle.
  - A new request on the port being acked in this cycle is not issued until the next cycle.
- Width: only mem_a[11:2] is decoded by memory. Aliasing above 4 KB is permitted and not flagged.

Test Plan:
1. Reset, then i_req=1 with i_addr=0x10 and MEM[4]=0xDEADBEEF → cycle 1: mem_cen=1, mem_a=0x10, mem_wen=0; cycle 2: i_ack=1, i_rdata=0xDEADBEEF, i_stall=0.
2. Store d_addr=0x20 with d_wdata=0x12345678, then load 0x20 → the store acks 1 cycle after issue; the load issues 2 cycles after the store and returns d_rdata=0x12345678 with d_err=0.
3. i_req and d_req rise together (load 0x8, fetch 0x0) → D issued in cycle 0 and d_ack in cycle 1; I issued in cycle 1 and i_ack in cycle 2; mem_cen=1 in both cycles 0 and 1.
4. d_req held continuously, re-presented each time after its ack, with i_req=1 and STARVE_MAX=4 → I issued no later than after the 4th D issue; starve returns to 0.
5. d_addr=0x22 load → mem_cen stays 0; next cycle d_ack=1, d_err=1, d_rdata=0; memory contents unchanged.
6. nrst pulsed low in the cycle after a D issue → no d_ack, mem_cen=0, owner=NONE; after release, a re-presented request completes normally.
